// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM states
// and the byte-lane helpers used to build memory requests.
package rv32_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } lsu_state_t;

  // funct3[1:0] encodes access width for both loads and stores.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wdata[7:0]}};
      2'b01:   r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW);
    else    ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
    return ok;
  endfunction

  function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3[1:0])
      2'b01:   ok = (off[0] == 1'b0);
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a loaded word and sign/zero-extends it.
module lsu_load_align
  import rv32_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output logic [31:0] val
);

  logic [31:0] lane;

  always_comb begin
    lane = rdata >> {off, 3'b000};
    case (f3)
      F3_LB:   val = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   val = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  val = {24'd0, lane[7:0]};
      F3_LHU:  val = {16'd0, lane[15:0]};
      default: val = lane;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store sequencer between execute and data memory,
// with alignment faults, response timeout and registered writeback.
module lsu_ctrl
  import rv32_lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_we,
  input  logic [2:0]  ex_f3,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_val,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_t  state_reg;
  logic        op_we_reg;
  logic [2:0]  op_f3_reg;
  logic [4:0]  op_rd_reg;
  logic [31:0] op_addr_reg;
  logic [7:0]  cnt_reg;

  logic        mem_req_reg, mem_we_reg;
  logic [3:0]  mem_be_reg;
  logic [31:0] mem_addr_reg, mem_wdata_reg;
  logic        wb_en_reg, err_reg;
  logic [4:0]  wb_reg_reg;
  logic [31:0] wb_val_reg, err_addr_reg;

  logic        accept, op_ok, timed_out;
  logic [31:0] load_val;

  assign ex_ready  = (state_reg == ST_IDLE) && !rst;
  assign accept    = ex_valid && ex_ready;
  assign op_ok     = f3_legal(ex_we, ex_f3) && addr_aligned(ex_f3, ex_addr[1:0]);
  // Completion takes priority over a timeout landing in the same cycle.
  assign timed_out = (cnt_reg >= CNT_LAST);

  lsu_load_align u_align (
    .rdata (mem_rdata),
    .off   (op_addr_reg[1:0]),
    .f3    (op_f3_reg),
    .val   (load_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      op_we_reg     <= 1'b0;
      op_f3_reg     <= 3'd0;
      op_rd_reg     <= 5'd0;
      op_addr_reg   <= 32'd0;
      cnt_reg       <= 8'd0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_be_reg    <= 4'd0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
      wb_en_reg     <= 1'b0;
      wb_reg_reg    <= 5'd0;
      wb_val_reg    <= 32'd0;
      err_reg       <= 1'b0;
      err_addr_reg  <= 32'd0;
    end else begin
      wb_en_reg <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_we_reg   <= ex_we;
            op_f3_reg   <= ex_f3;
            op_rd_reg   <= ex_rd;
            op_addr_reg <= ex_addr;
            cnt_reg     <= 8'd0;
            if (op_ok) begin
              state_reg     <= ST_REQ;
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= ex_we;
              mem_be_reg    <= byte_en(ex_f3, ex_addr[1:0]);
              mem_addr_reg  <= {ex_addr[31:2], 2'b00};
              mem_wdata_reg <= replicate(ex_f3, ex_wdata);
            end else begin
              err_reg      <= 1'b1;
              err_addr_reg <= ex_addr;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          cnt_reg <= cnt_reg + 8'd1;
          if (state_reg == ST_REQ && mem_gnt) begin
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= 4'd0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            if (op_we_reg) begin
              state_reg <= ST_IDLE;
            end else if (mem_rvalid) begin
              state_reg  <= ST_IDLE;
              wb_en_reg  <= (op_rd_reg != 5'd0);
              wb_reg_reg <= op_rd_reg;
              wb_val_reg <= load_val;
            end else begin
              state_reg <= ST_WAIT;
            end
          end else if (state_reg == ST_WAIT && mem_rvalid) begin
            state_reg  <= ST_IDLE;
            wb_en_reg  <= (op_rd_reg != 5'd0);
            wb_reg_reg <= op_rd_reg;
            wb_val_reg <= load_val;
          end else if (timed_out) begin
            state_reg     <= ST_IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_be_reg    <= 4'd0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            err_reg       <= 1'b1;
            err_addr_reg  <= op_addr_reg;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_be    = mem_be_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign wb_en     = wb_en_reg;
  assign wb_reg    = wb_reg_reg;
  assign wb_val    = wb_val_reg;
  assign err       = err_reg;
  assign err_addr  = err_addr_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: table of operations against a hand-timed memory, a
// writeback/fault scoreboard, plus timeout and reset-in-WAIT sequences.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_we = 1'b0;
  logic [2:0]  ex_f3 = 3'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic [31:0] ex_addr = 32'd0, ex_wdata = 32'd0;
  logic        ex_ready, mem_req, mem_we, wb_en, err;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, wb_val, err_addr;
  logic [4:0]  wb_reg;

  // Second instance with a short timeout.
  logic        t_ex_valid = 1'b0, t_mem_gnt = 1'b0, t_mem_rvalid = 1'b0;
  logic        t_ex_ready, t_mem_req, t_mem_we, t_wb_en, t_err;
  logic [3:0]  t_mem_be;
  logic [31:0] t_mem_addr, t_mem_wdata, t_wb_val, t_err_addr;
  logic [4:0]  t_wb_reg;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we),
    .ex_f3(ex_f3), .ex_rd(ex_rd), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_reg(wb_reg), .wb_val(wb_val),
    .err(err), .err_addr(err_addr)
  );

  lsu_ctrl #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .ex_valid(t_ex_valid), .ex_ready(t_ex_ready), .ex_we(1'b0),
    .ex_f3(3'b010), .ex_rd(5'd3), .ex_addr(32'h0000_0040), .ex_wdata(32'd0),
    .mem_req(t_mem_req), .mem_gnt(t_mem_gnt), .mem_we(t_mem_we), .mem_be(t_mem_be),
    .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata), .mem_rvalid(t_mem_rvalid),
    .mem_rdata(32'hFFFF_FFFF), .wb_en(t_wb_en), .wb_reg(t_wb_reg), .wb_val(t_wb_val),
    .err(t_err), .err_addr(t_err_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Scoreboard of expected writebacks and faults on the main instance.
  typedef struct {
    logic        is_err;
    logic [4:0]  r;
    logic [31:0] v;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (!rst && (wb_en || err)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_event", {30'd0, err, wb_en}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_kind_err", {31'd0, err}, {31'd0, e.is_err});
        if (e.is_err) begin
          check("sb_err_addr", err_addr, e.v);
        end else begin
          check("sb_wb_reg", {27'd0, wb_reg}, {27'd0, e.r});
          check("sb_wb_val", wb_val, e.v);
        end
      end
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, wdata, rdata;
    int          gd, rvd;
    logic        same, fault;
    logic [3:0]  be;
    logic [31:0] wd, val;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  initial begin
    vecs[0]  = '{1'b0, 3'b000, 5'd5,  32'h103, 32'h0,        32'h80FF_1234, 0, 0, 1'b0, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 3'b100, 5'd6,  32'h103, 32'h0,        32'h80FF_1234, 0, 0, 1'b0, 1'b0, 4'b1000, 32'h0, 32'h0000_0080};
    vecs[2]  = '{1'b1, 3'b001, 5'd0,  32'h202, 32'h0000_BEEF, 32'h0,        0, 0, 1'b0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[3]  = '{1'b0, 3'b010, 5'd1,  32'h101, 32'h0,        32'h0,         0, 0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 3'b100, 5'd0,  32'h100, 32'h1234,     32'h0,         0, 0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 3'b001, 5'd7,  32'h102, 32'h0,        32'h80FF_1234, 0, 0, 1'b0, 1'b0, 4'b1100, 32'h0, 32'hFFFF_80FF};
    vecs[6]  = '{1'b0, 3'b101, 5'd8,  32'h102, 32'h0,        32'h80FF_1234, 0, 0, 1'b0, 1'b0, 4'b1100, 32'h0, 32'h0000_80FF};
    vecs[7]  = '{1'b0, 3'b010, 5'd31, 32'h104, 32'h0,        32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 3'b000, 5'd0,  32'h301, 32'h1122_33A5, 32'h0,        0, 0, 1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[9]  = '{1'b1, 3'b010, 5'd0,  32'h400, 32'h1234_5678, 32'h0,        0, 0, 1'b0, 1'b0, 4'b1111, 32'h1234_5678, 32'h0};
    vecs[10] = '{1'b0, 3'b001, 5'd2,  32'h103, 32'h0,        32'h0,         0, 0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 3'b011, 5'd2,  32'h100, 32'h0,        32'h0,         0, 0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 3'b000, 5'd0,  32'h100, 32'h0,        32'h0000_0055, 3, 2, 1'b0, 1'b0, 4'b0001, 32'h0, 32'h0000_0055};
    vecs[13] = '{1'b0, 3'b101, 5'd9,  32'h100, 32'h0,        32'h1234_ABCD, 3, 2, 1'b0, 1'b0, 4'b0011, 32'h0, 32'h0000_ABCD};
    vecs[14] = '{1'b0, 3'b000, 5'd10, 32'h101, 32'h0,        32'h0000_7F00, 0, 0, 1'b1, 1'b0, 4'b0010, 32'h0, 32'h0000_007F};
    vecs[15] = '{1'b1, 3'b010, 5'd0,  32'h010, 32'hCAFE_F00D, 32'h0,        2, 0, 1'b0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
  end

  initial begin
    vec_t v;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_wb_en", {31'd0, wb_en}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, ex_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge clk);
      ex_valid = 1'b1; ex_we = v.we; ex_f3 = v.f3; ex_rd = v.rd;
      ex_addr = v.addr; ex_wdata = v.wdata;
      check("ready_at_accept", {31'd0, ex_ready}, 32'd1);
      if (v.fault) exp_q.push_back('{1'b1, 5'd0, v.addr});
      else if (!v.we && v.rd != 5'd0) exp_q.push_back('{1'b0, v.rd, v.val});
      @(negedge clk);
      ex_valid = 1'b0;
      if (v.fault) begin
        check("fault_no_req", {31'd0, mem_req}, 32'd0);
        check("fault_ready", {31'd0, ex_ready}, 32'd1);
      end else begin
        for (int c = 0; c <= v.gd; c++) begin
          check("req_held", {31'd0, mem_req}, 32'd1);
          check("req_we", {31'd0, mem_we}, {31'd0, v.we});
          check("req_addr", mem_addr, {v.addr[31:2], 2'b00});
          check("req_be", {28'd0, mem_be}, {28'd0, v.be});
          check("req_wdata", mem_wdata, v.wd);
          if (c == v.gd) begin
            mem_gnt = 1'b1;
            if (v.same) begin mem_rvalid = 1'b1; mem_rdata = v.rdata; end
          end
          @(negedge clk);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        if (!v.we && !v.same) begin
          for (int c = 0; c < v.rvd; c++) begin
            check("wait_not_ready", {31'd0, ex_ready}, 32'd0);
            @(negedge clk);
          end
          mem_rvalid = 1'b1; mem_rdata = v.rdata;
          @(negedge clk);
          mem_rvalid = 1'b0;
        end
        check("done_wb_en", {31'd0, wb_en}, {31'd0, (!v.we && v.rd != 5'd0)});
        check("done_ready", {31'd0, ex_ready}, 32'd1);
        check("done_req_low", {31'd0, mem_req}, 32'd0);
      end
    end

    // Timeout on the TIMEOUT=4 instance: err exactly 4 cycles after mem_req rises.
    @(negedge clk);
    t_ex_valid = 1'b1;
    @(negedge clk);
    t_ex_valid = 1'b0;
    check("to_req_rise", {31'd0, t_mem_req}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("to_no_err_yet", {31'd0, t_err}, 32'd0);
      check("to_req_held", {31'd0, t_mem_req}, 32'd1);
    end
    @(negedge clk);
    check("to_err", {31'd0, t_err}, 32'd1);
    check("to_err_addr", t_err_addr, 32'h0000_0040);
    check("to_req_drop", {31'd0, t_mem_req}, 32'd0);
    check("to_ready", {31'd0, t_ex_ready}, 32'd1);
    @(negedge clk);
    t_mem_rvalid = 1'b1; t_mem_gnt = 1'b1;
    check("to_err_one_cycle", {31'd0, t_err}, 32'd0);
    @(negedge clk);
    t_mem_rvalid = 1'b0; t_mem_gnt = 1'b0;
    check("to_stray_no_wb", {31'd0, t_wb_en}, 32'd0);
    check("to_stray_no_req", {31'd0, t_mem_req}, 32'd0);
    check("to_stray_no_err", {31'd0, t_err}, 32'd0);

    // Reset while in WAIT on the main instance.
    @(negedge clk);
    ex_valid = 1'b1; ex_we = 1'b0; ex_f3 = 3'b010; ex_rd = 5'd4; ex_addr = 32'h500;
    @(negedge clk);
    ex_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("wrst_ex_ready", {31'd0, ex_ready}, 32'd0);
    check("wrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("wrst_mem_be", {28'd0, mem_be}, 32'd0);
    check("wrst_mem_addr", mem_addr, 32'd0);
    check("wrst_wb_val", wb_val, 32'd0);
    check("wrst_err_addr", err_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("wrst_late_rvalid_no_wb", {31'd0, wb_en}, 32'd0);
    check("wrst_ready", {31'd0, ex_ready}, 32'd1);
    @(negedge clk);
    check("wrst_no_err", {31'd0, err}, 32'd0);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
